// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of the single data-memory port between the core LSU and the debug/loader port.
// Latency: stores complete in the grant cycle; load data returns on <owner>_rvalid exactly 1 cycle after gnt.
// Backpressure: the losing requester (and both during the load-return cycle) sees gnt low and holds its request.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  // core load/store path
  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_mask,
  output logic                core_gnt,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,
  // debug/loader path
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic [DATA_W/8-1:0] dbg_mask,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata,
  // data memory port
  output logic                mem_cs,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic {IDLE, RD_WAIT} state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;          // 0: core wins a tie, 1: dbg wins a tie
  logic   rd_owner_q, rd_owner_d;  // 0: core, 1: dbg owns the outstanding load
  logic   pick_dbg;
  logic   win_we;

  // Grant selection, memory-port muxing and load-return steering.
  // Reset gates every output so nothing leaks while the flops are being cleared.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    rd_owner_d  = rd_owner_q;
    core_gnt    = 1'b0;
    dbg_gnt     = 1'b0;
    core_rvalid = 1'b0;
    dbg_rvalid  = 1'b0;
    core_rdata  = '0;
    dbg_rdata   = '0;
    mem_cs      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_mask    = '0;
    pick_dbg    = dbg_req && (!core_req || prio_q);
    win_we      = pick_dbg ? dbg_we : core_we;

    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (core_req || dbg_req) begin
            core_gnt  = !pick_dbg;
            dbg_gnt   = pick_dbg;
            mem_cs    = 1'b1;
            mem_wr    = win_we;
            mem_addr  = pick_dbg ? dbg_addr  : core_addr;
            mem_wdata = pick_dbg ? dbg_wdata : core_wdata;
            mem_mask  = pick_dbg ? dbg_mask  : core_mask;
            // The side just served goes to the back of the line.
            prio_d    = !pick_dbg;
            if (!win_we) begin
              rd_owner_d = pick_dbg;
              state_d    = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // Memory returns read data now; no new access may start this cycle.
          if (rd_owner_q) begin
            dbg_rvalid = 1'b1;
            dbg_rdata  = mem_rdata;
          end else begin
            core_rvalid = 1'b1;
            core_rdata  = mem_rdata;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, round-robin pointer and load owner registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized + directed stimulus against a transaction-level reference model.
// Latency: expectations are pushed when inputs are applied and popped by the monitor half a cycle later.
// Backpressure: bench requesters hold their transaction until the model says it was granted.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic [3:0]  core_mask, dbg_mask;
  logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] core_rdata, dbg_rdata;
  logic        mem_cs, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_mask(core_mask),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_mask(dbg_mask),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  // ---------------- memory contents (device side and model side kept separately)
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Behavioural data memory: writes land at the edge, reads return one cycle later;
  // otherwise the read bus carries noise so any ungated rdata shows up.
  always @(posedge clk) begin
    if (mem_cs && mem_wr) dev_mem[mem_addr] = merge(dev_read(mem_addr), mem_wdata, mem_mask);
    if (mem_cs && !mem_wr) mem_rdata <= dev_read(mem_addr);
    else                   mem_rdata <= $urandom;
  end

  // ---------------- reference model
  typedef struct {
    logic        cg, dg, cs, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  mask;
    logic        cv, dv;
    logic [31:0] crd, drd;
  } exp_t;

  exp_t        exp_q[$];
  int          last_win = 2;   // 0 core, 1 dbg, 2 nobody since reset
  bit          pend = 0;       // a load result is due this cycle
  bit          pend_dbg = 0;
  logic [31:0] pend_data = 0;
  bit          g_core, g_dbg;  // model's grant decision for the current cycle
  int          cyc = 0;

  // Evaluate the current cycle's inputs against the arbitration rules and queue the expected outputs.
  task automatic eval();
    exp_t e;
    bit   wd;
    e = '{cg:0, dg:0, cs:0, wr:0, addr:0, wdata:0, mask:0, cv:0, dv:0, crd:0, drd:0};
    g_core = 0;
    g_dbg  = 0;
    if (reset) begin
      last_win = 2;
      pend     = 0;
    end else if (pend) begin
      if (pend_dbg) begin e.dv = 1; e.drd = pend_data; end
      else          begin e.cv = 1; e.crd = pend_data; end
      pend = 0;
    end else if (core_req || dbg_req) begin
      // A tie goes to whoever was not served last; core if nobody has been served.
      wd     = (core_req && dbg_req) ? (last_win == 0) : dbg_req;
      g_core = !wd;
      g_dbg  = wd;
      e.cg   = !wd;
      e.dg   = wd;
      e.cs   = 1;
      e.wr   = wd ? dbg_we : core_we;
      e.addr = wd ? dbg_addr : core_addr;
      e.wdata = wd ? dbg_wdata : core_wdata;
      e.mask = wd ? dbg_mask : core_mask;
      if (e.wr) ref_mem[e.addr] = merge(ref_read(e.addr), e.wdata, e.mask);
      else begin
        pend      = 1;
        pend_dbg  = wd;
        pend_data = ref_read(e.addr);
      end
      last_win = wd ? 1 : 0;
    end
    exp_q.push_back(e);
  endtask

  // ---------------- checking
  int n_chk = 0, n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, req);
  endfunction

  // Monitor: whenever an expectation is outstanding, compare every output against it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("core_gnt",    core_gnt,    e.cg);
        chk("dbg_gnt",     dbg_gnt,     e.dg);
        chk("mem_cs",      mem_cs,      e.cs);
        chk("mem_wr",      mem_wr,      e.wr);
        chk("mem_addr",    mem_addr,    e.addr);
        chk("mem_wdata",   mem_wdata,   e.wdata);
        chk("mem_mask",    mem_mask,    e.mask);
        chk("core_rvalid", core_rvalid, e.cv);
        chk("core_rdata",  core_rdata,  e.crd);
        chk("dbg_rvalid",  dbg_rvalid,  e.dv);
        chk("dbg_rdata",   dbg_rdata,   e.drd);
      end
    end
  end

  // ---------------- stimulus
  task automatic drv(input bit rst,
                     input bit creq, input bit cwe, input logic [31:0] caddr,
                     input logic [31:0] cwd, input logic [3:0] cm,
                     input bit dreq, input bit dwe, input logic [31:0] daddr,
                     input logic [31:0] dwd, input logic [3:0] dm);
    @(posedge clk);
    #1;
    cyc++;
    reset = rst;
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd; core_mask = cm;
    dbg_req  = dreq; dbg_we  = dwe; dbg_addr  = daddr; dbg_wdata  = dwd; dbg_mask  = dm;
    eval();
  endtask

  task automatic idle(input bit rst);
    drv(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // random requester state
  bit          ca_p, ca_we, da_p, da_we;
  logic [31:0] ca_addr, ca_wd, da_addr, da_wd;
  logic [3:0]  ca_m, da_m;

  initial begin
    reset = 1;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_mask = 0;
    dbg_req  = 0; dbg_we  = 0; dbg_addr  = 0; dbg_wdata  = 0; dbg_mask  = 0;

    // Reset state: requests present during reset must not be granted.
    drv(1, 1, 0, 32'h4, 32'h1, 4'hF, 1, 1, 32'h8, 32'h2, 4'hF);
    idle(1);

    // 1: lone core load, data one cycle later.
    drv(0, 1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0);
    idle(0);

    // 2: both store every cycle -> alternating grants, no gaps.
    idle(1);
    for (int i = 0; i < 6; i++)
      drv(0, 1, 1, 32'h40 + i * 4, 32'hC0DE0000 + i, 4'hF, 1, 1, 32'h80 + i * 4, 32'hDB600000 + i, 4'hF);

    // 3: both load -> core, wait, dbg, wait.
    idle(1);
    for (int i = 0; i < 4; i++)
      drv(0, 1, 0, 32'h40, 0, 4'hF, 1, 0, 32'h80, 0, 4'hF);

    // 4: dbg partial store, then read it back through dbg.
    drv(0, 0, 0, 0, 0, 0, 1, 1, 32'h22, 32'h00AB0000, 4'b0100);
    drv(0, 0, 0, 0, 0, 0, 1, 0, 32'h22, 0, 4'hF);
    idle(0);

    // 5: reset during RD_WAIT discards the load; next contest goes to core.
    drv(0, 1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0);
    idle(1);
    drv(0, 1, 1, 32'h30, 32'h11111111, 4'hF, 1, 1, 32'h34, 32'h22222222, 4'hF);
    drv(0, 0, 0, 0, 0, 0, 1, 1, 32'h34, 32'h22222222, 4'hF);

    // 6: dbg withdraws while core is served; no dbg access reaches memory.
    idle(1);
    drv(0, 1, 0, 32'h50, 0, 4'hF, 1, 1, 32'h54, 32'hDEADBEEF, 4'hF);
    drv(0, 0, 0, 0, 0, 0, 1, 1, 32'h54, 32'hDEADBEEF, 4'hF);
    drv(0, 1, 1, 32'h58, 32'h12345678, 4'h3, 0, 0, 0, 0, 0);
    idle(0);

    // Random traffic: requesters hold until granted, occasionally withdraw; rare resets.
    ca_p = 0; da_p = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!ca_p && $urandom_range(99) < 60) begin
        ca_p = 1; ca_we = $urandom_range(1); ca_addr = $urandom_range(15) * 4;
        ca_wd = $urandom; ca_m = $urandom_range(15);
      end else if (ca_p && $urandom_range(99) < 4) ca_p = 0;
      if (!da_p && $urandom_range(99) < 50) begin
        da_p = 1; da_we = $urandom_range(1); da_addr = $urandom_range(15) * 4;
        da_wd = $urandom; da_m = $urandom_range(15);
      end else if (da_p && $urandom_range(99) < 4) da_p = 0;
      drv($urandom_range(199) == 0, ca_p, ca_we, ca_addr, ca_wd, ca_m,
          da_p, da_we, da_addr, da_wd, da_m);
      if (g_core) ca_p = 0;
      if (g_dbg)  da_p = 0;
    end
    idle(0);
    idle(0);

    // Drain: the monitor must consume every expectation within a few cycles.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
